// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz from a 100 MHz clock) and helpers
// for the sync generator and the graphics blocks.
package vga_pkg;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_DIV       = 4;

    localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned CNT_W = 10;

    // True when lo <= v < hi_excl, unsigned.
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input int unsigned lo,
                                       input int unsigned hi_excl);
        return (32'(v) >= lo) && (32'(v) < hi_excl);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing outputs of the VGA sync generator as seen by downstream graphics logic.
interface vga_sync_if;
    import vga_pkg::*;

    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             p_tick;
    logic             frame_end;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;

    modport master (output hsync, vsync, video_on, p_tick, frame_end, pix_x, pix_y);
    modport slave  (input  hsync, vsync, video_on, p_tick, frame_end, pix_x, pix_y);

endinterface

// File: rtl/vga_pix_div.sv
// Pixel-clock enable: divides clk by DIV, p_tick high while the divider sits at DIV-1.
module vga_pix_div
    import vga_pkg::*;
#(
    parameter int unsigned DIV = VGA_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic o_p_tick,
    output logic o_p_tick_next_c
);

    localparam int unsigned    DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_p_tick;

    always_comb begin
        w_div_next = '0;
        if (reset && (r_div != DIV_LAST)) begin
            w_div_next = r_div + DIV_W'(1);
        end
    end

    // Look-ahead tick lets the parent register its decodes in step with p_tick.
    assign o_p_tick_next_c = reset && (w_div_next == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div    <= '0;
            r_p_tick <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_p_tick <= o_p_tick_next_c;
        end
    end

    assign o_p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel/line counters with registered sync, blanking and
// end-of-frame outputs, all aligned with pix_x/pix_y.
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned DIV       = VGA_DIV
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master o_vga
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

    logic             w_p_tick;
    logic             w_p_tick_next;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_end;

    vga_pix_div #(.DIV(DIV)) u_pix_div (
        .clk             (clk),
        .reset           (reset),
        .o_p_tick        (w_p_tick),
        .o_p_tick_next_c (w_p_tick_next)
    );

    // Next counter values; sync and blanking are decoded from these so they
    // land in the same cycle as the counts they describe.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (!reset) begin
            w_x_next = '0;
            w_y_next = '0;
        end else if (w_p_tick) begin
            if (r_x == X_LAST) begin
                w_x_next = '0;
                w_y_next = (r_y == Y_LAST) ? '0 : r_y + CNT_W'(1);
            end else begin
                w_x_next = r_x + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_video_on  <= 1'b1;
            r_frame_end <= 1'b0;
        end else begin
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_hsync     <= !in_window(w_x_next, HS_START, HS_END);
            r_vsync     <= !in_window(w_y_next, VS_START, VS_END);
            r_video_on  <= in_window(w_x_next, 0, H_DISPLAY) && in_window(w_y_next, 0, V_DISPLAY);
            r_frame_end <= w_p_tick_next && (w_x_next == X_LAST) && (w_y_next == Y_LAST);
        end
    end

    assign o_vga.hsync     = r_hsync;
    assign o_vga.vsync     = r_vsync;
    assign o_vga.video_on  = r_video_on;
    assign o_vga.p_tick    = w_p_tick;
    assign o_vga.frame_end = r_frame_end;
    assign o_vga.pix_x     = r_x;
    assign o_vga.pix_y     = r_y;

endmodule
